// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - opcodes, command word fields and FSM states for the SPI command dispatcher
package spi_cmd_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_WRITE   = 4'h1;
  localparam logic [3:0] OP_SET     = 4'h2;
  localparam logic [3:0] OP_CLR     = 4'h3;
  localparam logic [3:0] OP_PUSH    = 4'h4;
  localparam logic [3:0] OP_CLRSTAT = 4'h5;
  localparam logic [3:0] OP_SOFTRST = 4'hF;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int ADDR_MSB = 11;
  localparam int ADDR_LSB = 8;
  localparam int DAT_MSB  = 7;
  localparam int DAT_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_EXEC    = 2'd2
  } state_e;

endpackage

// File: rtl/spi_cmd_fifo.sv
// rtl/spi_cmd_fifo.sv - FIFO_DEPTH x 8 synchronous stream FIFO with flush
module spi_cmd_fifo
  import spi_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic [7:0]  push_data,
  input  logic        pop,
  input  logic        flush,
  output logic [7:0]  rd_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    do_push  = push & (~full | do_pop) & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spi_cmd_dispatch.sv
// rtl/spi_cmd_dispatch.sv - detects SPI end-of-frame, decodes the 16-bit word and applies it
// to the config register file or the stream FIFO.
module spi_cmd_dispatch
  import spi_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         spi_cs,
  input  logic [15:0]  spi_data,
  output logic [127:0] cfg_regs,
  output logic         cfg_wr_stb,
  output logic [3:0]   cfg_wr_addr,
  output logic [7:0]   stream_data,
  output logic         stream_valid,
  input  logic         stream_ready,
  output logic         fifo_overflow,
  output logic [7:0]   bad_cmd_cnt,
  output logic [15:0]  frame_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   cs_rise;

  state_e          state_q, state_d;
  logic [15:0]     word_q, word_d;
  logic [15:0]     frame_q, frame_d;
  logic [15:0][7:0] regs_q, regs_d;
  logic            stb_q, stb_d;
  logic [3:0]      stb_addr_q, stb_addr_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      bad_q, bad_d;

  logic [3:0]      op;
  logic [3:0]      addr;
  logic [7:0]      dat;

  logic            fifo_push, fifo_pop, fifo_flush;
  logic            fifo_full, fifo_empty;
  logic [AW:0]     fifo_count;
  logic [7:0]      fifo_rdata;

  assign op   = word_q[OP_MSB:OP_LSB];
  assign addr = word_q[ADDR_MSB:ADDR_LSB];
  assign dat  = word_q[DAT_MSB:DAT_LSB];

  // Synchroniser and edge history reset high so leaving reset with CS idle is not a frame.
  assign sync_d    = {sync_q[SYNC_STAGES-2:0], spi_cs};
  assign cs_prev_d = sync_q[SYNC_STAGES-1];
  assign cs_rise   = sync_q[SYNC_STAGES-1] & ~cs_prev_q;

  assign stream_valid = (fifo_count != '0);
  assign stream_data  = fifo_empty ? 8'h00 : fifo_rdata;
  assign fifo_pop     = stream_valid & stream_ready;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    frame_d    = frame_q;
    regs_d     = regs_q;
    stb_d      = 1'b0;
    stb_addr_d = stb_addr_q;
    ovf_d      = ovf_q;
    bad_d      = bad_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_rise) begin
          word_d  = spi_data;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        frame_d = frame_q + 16'd1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        case (op)
          OP_NOP: begin
          end
          OP_WRITE: begin
            regs_d[addr] = dat;
            stb_d        = 1'b1;
            stb_addr_d   = addr;
          end
          OP_SET: begin
            regs_d[addr] = regs_q[addr] | dat;
            stb_d        = 1'b1;
            stb_addr_d   = addr;
          end
          OP_CLR: begin
            regs_d[addr] = regs_q[addr] & ~dat;
            stb_d        = 1'b1;
            stb_addr_d   = addr;
          end
          OP_PUSH: begin
            fifo_push = 1'b1;
            if (fifo_full && !fifo_pop) ovf_d = 1'b1;
          end
          OP_CLRSTAT: begin
            ovf_d = 1'b0;
            bad_d = 8'h00;
          end
          OP_SOFTRST: begin
            regs_d     = '0;
            fifo_flush = 1'b1;
            stb_d      = 1'b1;
            stb_addr_d = 4'hF;
          end
          default: begin
            if (bad_q != 8'hFF) bad_d = bad_q + 8'd1;
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '1;
      cs_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      word_q     <= '0;
      frame_q    <= '0;
      regs_q     <= '0;
      stb_q      <= 1'b0;
      stb_addr_q <= '0;
      ovf_q      <= 1'b0;
      bad_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      cs_prev_q  <= cs_prev_d;
      state_q    <= state_d;
      word_q     <= word_d;
      frame_q    <= frame_d;
      regs_q     <= regs_d;
      stb_q      <= stb_d;
      stb_addr_q <= stb_addr_d;
      ovf_q      <= ovf_d;
      bad_q      <= bad_d;
    end
  end

  spi_cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .push_data(dat),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .rd_data  (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign cfg_regs      = regs_q;
  assign cfg_wr_stb    = stb_q;
  assign cfg_wr_addr   = stb_addr_q;
  assign fifo_overflow = ovf_q;
  assign bad_cmd_cnt   = bad_q;
  assign frame_cnt     = frame_q;

endmodule
